// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
// The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

  // FETCH..JAL follow the classic multicycle flow; TRAP parks on an undecoded opcode
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_READDATA = 2'b01;
  localparam logic [1:0] RES_ALURES   = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from ALUOp and instruction funct fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7[5] only means sub for R-type; for addi it is an immediate bit
          3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional ILLEGAL_TRAP_EN adds a sticky IllegalInstr flag and a TRAP state.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        MemReq,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
`ifdef ILLEGAL_TRAP_EN
  output logic        IllegalInstr,
`endif
  output logic        RegWrite
);

  state_e     state_q, state_d;
  alu_op_e    alu_op;
  logic [6:0] opcode;
  logic       unused_instr;

  assign opcode       = Instr[6:0];
  assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_d    = illegal_q | (state_q == S_DECODE && state_d == S_TRAP);
  assign IllegalInstr = illegal_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_op    = ALUOP_ADD;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    MemReq    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    case (state_q)
      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = Instr[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        PCWrite = Zero;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
    // Strobes are killed during reset so an abandoned access never commits
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemReq   = 1'b0;
    end
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (opcode)
      OP_STORE: ImmSrc = IMM_S;
      OP_BEQ:   ImmSrc = IMM_B;
      OP_JAL:   ImmSrc = IMM_J;
      default:  ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (Instr[14:12]),
    .funct7_5    (Instr[30]),
    .op_5        (Instr[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences the multicycle RISC-V datapath: fetch, decode, execute, memory and writeback. It drives the immediate-extender select (ImmSrc), ALU operand and operation selects, and all architectural write strobes. It waits on a single memory ready handshake. It sits between the instruction register and every datapath mux and enable, replacing per-instruction combinational control.

## Interface
Parameters:
- none

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- Instr  in  32  instruction register contents; valid from DECODE onward
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result
- MemWrite  out  1  data memory write strobe
- MemReq  out  1  memory access request
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALU result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data
- ALUSrcB  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write strobe
- IllegalInstr  out  1  sticky illegal-opcode flag; present only with the macro

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP (TRAP with macro only).
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add.
  - Hold while MemReady=0.
  - On MemReady=1: IRWrite=1, PCWrite=1, go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). Dispatch on Instr[6:0]:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → illegal handling (see Configuration)
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD if Instr[5]=0, else MEMWRITE.
- MEMREAD:
  - MemReq=1, AdrSrc=1.
  - Hold until MemReady, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, go to FETCH.
- MEMWRITE:
  - MemReq=1, AdrSrc=1, MemWrite=1.
  - Hold until MemReady, then go to FETCH.
  - MemWrite stays asserted throughout the wait.
- EXECUTER / EXECUTEI:
  - ALUSrcA=10; ALUSrcB=00 (EXECUTER) or 01 (EXECUTEI).
  - ALUControl from funct3/funct7[5]; go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, go to FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=Zero; go to FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; go to ALUWB.
- ImmSrc is combinational from Instr[6:0] in every state:
  - loads / I-ALU → 00
  - stores → 01
  - branches → 10
  - jal → 11
  - other → 00
- ALU decode:
  - ALUOp add (loads, stores, jal) → 000.
  - ALUOp sub (beq) → 001.
  - Funct decode for opcodes 0110011/0010011:
    - funct3 000 → 001 when op[5]&funct7[5], else 000
    - funct3 010 → 101
    - funct3 110 → 011
    - funct3 111 → 010
    - other → 000
- Outputs not listed for a state are 0.

## Timing
- Moore outputs except: ImmSrc; ALUControl; FETCH's IRWrite/PCWrite (gated by MemReady); BEQ's PCWrite (gated by Zero).
- Latency with MemReady tied high:
  - lw 5 cycles
  - sw, R-type, I-type, jal 4 cycles
  - beq 3 cycles
- Each MemReady=0 cycle adds one cycle to FETCH, MEMREAD or MEMWRITE.
- While reset=1:
  - PCWrite, IRWrite, RegWrite, MemWrite, MemReq forced 0.
  - State loads FETCH at the edge.
  - IllegalInstr clears to 0.
- Reset during a memory wait: the access is abandoned and the next cycle is FETCH.
- No other input can pre-empt a state.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An undecoded opcode in DECODE goes to TRAP and sets IllegalInstr=1.
  - TRAP holds with all strobes 0 until reset.
- ILLEGAL_TRAP_EN undefined:
  - An undecoded opcode in DECODE goes to FETCH (NOP; PC already advanced).
  - The IllegalInstr port and the TRAP state are absent.

## Structure
- Package riscv_ctrl_pkg contains:
  - the state enum
  - opcode constants
  - ImmSrc, ALUControl, ResultSrc and ALUSrc encodings
- Sub-module alu_decoder: combinational; (ALUOp, funct3, funct7[5], op[5]) → ALUControl.

## Test plan
- addi 0x00A00093, MemReady=1 → FETCH, DECODE, EXECUTEI, ALUWB; ImmSrc=00, ALUSrcB=01, RegWrite=1 in cycle 4 only.
- lw 0x0000A103 with MemReady low 2 cycles in MEMREAD → 7 cycles total; AdrSrc=1 throughout MEMREAD; ResultSrc=01, RegWrite=1 in MEMWB.
- sw 0x0020A223 → ImmSrc=01; MemWrite=1 only in MEMWRITE; RegWrite never asserts.
- beq 0x00000463 with Zero=1 then Zero=0 → ImmSrc=10, ALUControl=001; PCWrite=1 in BEQ only when Zero=1.
- Instr 0x00000000 → with ILLEGAL_TRAP_EN: TRAP, IllegalInstr=1 until reset. Without: FETCH next cycle.
- Reset asserted mid-MEMWRITE wait → MemWrite=0 in the reset cycle; state FETCH after the edge; no RegWrite.
